// File: rtl/feature_framer.sv
// Packs UART bytes MSB-first into D_WL-bit feature words and ping-pongs frames to the LSTM core.
// Optional partial-word timeout: define FRAMER_BYTE_TIMEOUT_EN.
module feature_framer #(
  parameter int INPUT_SIZE  = 26,
  parameter int TIME_STEP   = 148,
  parameter int D_WL        = 24,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_byte,
  input  logic            w_x_en,
  output logic            f_in_valid,
  output logic [D_WL-1:0] feature_in,
  output logic            seq_done,
  output logic            overflow
);

  localparam int NB  = D_WL / 8;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int FW  = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
  localparam int SRW = D_WL - 8;

  generate
    if ((D_WL % 8) != 0 || D_WL < 16 || INPUT_SIZE < 1 || TIME_STEP < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("feature_framer: unsupported parameter set");
    end
  endgenerate

  typedef enum logic {IDLE, STREAM} state_t;

  // Both frame buffers share one RAM, addressed {buffer, word}
  logic [D_WL-1:0] mem_reg [2**(IW+1)];

  logic [BW-1:0]   byte_cnt_reg;
  logic [SRW-1:0]  sr_reg;
  logic [IW-1:0]   wr_idx_reg;
  logic            wr_sel_reg;
  logic [1:0]      full_reg;
  logic            overflow_reg;

  state_t          state_reg;
  logic [IW-1:0]   rd_idx_reg;
  logic            rd_sel_reg;
  logic [FW-1:0]   frame_cnt_reg;
  logic            seq_pend_reg;
  logic            seq_done_reg;
  logic            f_in_valid_reg;
  logic [D_WL-1:0] feature_in_reg;

  logic            accept;
  logic            last_byte;
  logic            last_word;
  logic            wr_en;
  logic [D_WL-1:0] word_next;
  logic            issue;
  logic            rd_last;
  logic            timeout_hit;

  assign accept    = rx_valid && !full_reg[wr_sel_reg];
  assign last_byte = (byte_cnt_reg == BW'(NB - 1));
  assign last_word = (wr_idx_reg == IW'(INPUT_SIZE - 1));
  assign wr_en     = accept && last_byte;
  assign word_next = {sr_reg, rx_byte};

  // A full read buffer is served in the same cycle the FSM leaves IDLE
  assign issue   = w_x_en && ((state_reg == STREAM) || full_reg[rd_sel_reg]);
  assign rd_last = issue && (rd_idx_reg == IW'(INPUT_SIZE - 1));

`ifdef FRAMER_BYTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt_reg;

  assign timeout_hit = (byte_cnt_reg != '0) && !rx_valid && (idle_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || rx_valid || (byte_cnt_reg == '0) || timeout_hit) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_reg <= '0;
      sr_reg       <= '0;
      wr_idx_reg   <= '0;
      wr_sel_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (rx_valid && full_reg[wr_sel_reg]) begin
        overflow_reg <= 1'b1;
      end
      if (accept) begin
        sr_reg <= SRW'({sr_reg, rx_byte});
        if (last_byte) begin
          byte_cnt_reg <= '0;
          if (last_word) begin
            wr_idx_reg <= '0;
            wr_sel_reg <= ~wr_sel_reg;
          end else begin
            wr_idx_reg <= wr_idx_reg + 1'b1;
          end
        end else begin
          byte_cnt_reg <= byte_cnt_reg + 1'b1;
        end
      end else if (timeout_hit) begin
        byte_cnt_reg <= '0;
        sr_reg       <= '0;
      end
    end
  end

  // Set and clear never target the same buffer: writer only fills an empty one
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
      always_ff @(posedge clk) begin
        if (rst) begin
          full_reg[gi] <= 1'b0;
        end else if (wr_en && last_word && (wr_sel_reg == 1'(gi))) begin
          full_reg[gi] <= 1'b1;
        end else if (rd_last && (rd_sel_reg == 1'(gi))) begin
          full_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[{wr_sel_reg, wr_idx_reg}] <= word_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feature_in_reg <= '0;
    end else if (issue) begin
      feature_in_reg <= mem_reg[{rd_sel_reg, rd_idx_reg}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rd_idx_reg     <= '0;
      rd_sel_reg     <= 1'b0;
      frame_cnt_reg  <= '0;
      seq_pend_reg   <= 1'b0;
      seq_done_reg   <= 1'b0;
      f_in_valid_reg <= 1'b0;
    end else begin
      f_in_valid_reg <= issue;
      seq_done_reg   <= seq_pend_reg;
      seq_pend_reg   <= 1'b0;

      unique case (state_reg)
        IDLE:    if (full_reg[rd_sel_reg]) state_reg <= STREAM;
        STREAM:  ;
        default: state_reg <= IDLE;
      endcase

      if (issue) begin
        if (rd_last) begin
          rd_idx_reg <= '0;
          rd_sel_reg <= ~rd_sel_reg;
          state_reg  <= full_reg[~rd_sel_reg] ? STREAM : IDLE;
          if (frame_cnt_reg == FW'(TIME_STEP - 1)) begin
            frame_cnt_reg <= '0;
            seq_pend_reg  <= 1'b1;
          end else begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
          end
        end else begin
          rd_idx_reg <= rd_idx_reg + 1'b1;
        end
      end
    end
  end

  assign f_in_valid = f_in_valid_reg;
  assign feature_in = feature_in_reg;
  assign seq_done   = seq_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_feature_framer.sv
// Scoreboard bench for feature_framer: frame-level reference model feeds an expected-word queue.
module tb_feature_framer;
  localparam int IS = 2;
  localparam int TS = 3;
  localparam int DW = 24;
  localparam int TO = 10;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          w_x_en = 1'b0;
  logic          f_in_valid;
  logic [DW-1:0] feature_in;
  logic          seq_done;
  logic          overflow;

  feature_framer #(.INPUT_SIZE(IS), .TIME_STEP(TS), .D_WL(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .w_x_en(w_x_en),
    .f_in_valid(f_in_valid), .feature_in(feature_in), .seq_done(seq_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_frame[$];
  logic [DW-1:0] acc = '0;
  int  nb = 0;
  int  pending = 0;
  bit  exp_ovf = 0;
  bit  exp_seq = 0;
  int  word_in_frame = 0, frames_out = 0, words_out = 0, seq_pulses = 0, valid_seen = 0;
  bit  lat_armed = 0;
  int  lat_strobe_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_frame.delete();
    acc = '0; nb = 0; pending = 0; exp_ovf = 0; exp_seq = 0;
    word_in_frame = 0; frames_out = 0; lat_armed = 0;
  endtask

  // One cycle of byte stimulus; the model decides acceptance from frames still held.
  task automatic drive(input bit v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_byte  = v ? b : 8'h00;
    if (v) begin
      if (pending == 2) begin
        exp_ovf = 1;
      end else begin
        acc = (acc << 8) | DW'(b);
        nb++;
        if (nb == NB) begin
          cur_frame.push_back(acc);
          acc = '0; nb = 0;
          if (cur_frame.size() == IS) begin
            foreach (cur_frame[i]) exp_q.push_back(cur_frame[i]);
            cur_frame.delete();
            pending++;
            lat_strobe_idx = cyc + 1;
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic send_rand(input int n);
    repeat (n) drive(1'b1, 8'($urandom_range(0, 255)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    drive(1'b0, 8'h00);
    w_x_en = 1'b1;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops expected words, tracks frame ends and the sequence-end pulse.
  initial begin
    logic [DW-1:0] exp_w;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      check("seq_done", seq_done, exp_seq);
      if (seq_done) seq_pulses++;
      exp_seq = 0;
      check("overflow", overflow, exp_ovf);
      if (!w_x_en) check("stall_valid", f_in_valid, 0);
      if (f_in_valid) begin
        valid_seen++;
        if (lat_armed) begin
          check("latency", cyc + 1 - lat_strobe_idx, 2);
          lat_armed = 0;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", feature_in);
        end else begin
          exp_w = exp_q.pop_front();
          check("feature_in", feature_in, exp_w);
          words_out++;
          word_in_frame++;
          if (word_in_frame == IS) begin
            word_in_frame = 0;
            pending--;
            frames_out++;
            if (frames_out == TS) begin
              frames_out = 0;
              exp_seq = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, s0, v0, run, n;
    bit v;
    do_reset();
    check("rst_f_in_valid", f_in_valid, 0);
    check("rst_feature_in", feature_in, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_overflow", overflow, 0);

    // Ordering and first-word latency
    w_x_en = 1'b1;
    w0 = words_out;
    drive(1, 8'h12); drive(1, 8'h34); drive(1, 8'h56);
    drive(1, 8'hAB); drive(1, 8'hCD);
    lat_armed = 1;
    drive(1, 8'hEF);
    drain(50);
    check("order_words", words_out - w0, 2);

    // Stall after the first word of a frame
    w0 = words_out;
    drive(1, 8'h65); drive(1, 8'h43); drive(1, 8'h21);
    drive(1, 8'hFE); drive(1, 8'hDC); drive(1, 8'hBA);
    drive(0, 8'h00);
    n = 0;
    while (words_out == w0 && n < 20) begin @(negedge clk); n++; end
    w_x_en = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_hold", words_out - w0, 1);
    drain(50);
    check("stall_words", words_out - w0, 2);

    // Overflow: third frame dropped while both buffers full
    do_reset();
    w_x_en = 1'b0;
    w0 = words_out;
    send_rand(3 * IS * NB);
    idle(1);
    check("overflow_set", overflow, 1);
    drain(100);
    check("overflow_words", words_out - w0, 2 * IS);

    // Reset discards a pending frame and a partial word
    do_reset();
    w_x_en = 1'b0;
    send_rand(IS * NB + 2);
    idle(1);
    do_reset();
    w_x_en = 1'b1;
    v0 = valid_seen;
    idle(10);
    check("post_reset_valid", valid_seen - v0, 0);
    drive(1, 8'h00); drive(1, 8'h00); drive(1, 8'h01);
    send_rand(NB);
    drain(50);

    // Sequence end after TS frames
    do_reset();
    w_x_en = 1'b1;
    s0 = seq_pulses;
    send_rand(4 * IS * NB);
    drain(100);
    check("seq_pulses_4fr", seq_pulses - s0, 1);
    send_rand(2 * IS * NB);
    drain(100);
    check("seq_pulses_6fr", seq_pulses - s0, 2);

`ifdef FRAMER_BYTE_TIMEOUT_EN
    do_reset();
    w_x_en = 1'b1;
    drive(1, 8'hFF);
    idle(12);
    acc = '0; nb = 0;
    drive(1, 8'h11); drive(1, 8'h22); drive(1, 8'h33);
    send_rand(NB);
    drain(50);
`endif

    // Randomised traffic with random back-pressure
    do_reset();
    run = 0;
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) != 0) || (run >= 3);
      run = v ? 0 : run + 1;
      drive(v, 8'($urandom_range(0, 255)));
      w_x_en = ($urandom_range(0, 9) < 7);
    end
    w_x_en = 1'b1;
    n = 0;
    while ((nb != 0 || cur_frame.size() != 0) && n < 200) begin
      send_rand(1);
      n++;
    end
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
